// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: debounced mode/inc buttons driving a RUN/SET_H/SET_M time-set FSM
// with a one-cycle load, a count enable and a blinking blank mask for the edited pair.
module clock_set_ctrl #(
   parameter int DEBOUNCE_MAX = 20,
   parameter int BLINK_MAX    = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [7:0] cur_hour,
   input  logic [7:0] cur_min,
   output logic       run_en,
   output logic       load,
   output logic [7:0] load_hour,
   output logic [7:0] load_min,
   output logic [5:0] blank
);
   localparam int DW = $clog2(DEBOUNCE_MAX + 1);
   localparam int BW = $clog2(BLINK_MAX + 1);
   typedef enum logic [1:0] {RUN, SET_H, SET_M} state_t;
   state_t state, state_n;
   logic [1:0] s1, s2, db, db_d, press;
   logic [DW-1:0] dcnt [2];
   logic [BW-1:0] bcnt, bcnt_n;
   logic phase, phase_n, mode_p, inc_p, inc_ok, hour_ok, min_ok;
   logic [7:0] hour_n, min_n, hour_inc, min_inc;
   logic [5:0] blank_n;
   // bit 0 = mode, bit 1 = inc
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         db   <= '0;
         db_d <= '0;
         dcnt <= '{default: '0};
      end else begin
         s1   <= {btn_inc, btn_mode};
         s2   <= s1;
         db_d <= db;
         for (int i = 0; i < 2; i++)
            if (s2[i] != db[i]) begin
               if (dcnt[i] == DW'(DEBOUNCE_MAX)) begin
                  db[i]   <= s2[i];
                  dcnt[i] <= '0;
               end else
                  dcnt[i] <= dcnt[i] + DW'(1);
            end else
               dcnt[i] <= '0;
      end
   assign press  = db & ~db_d;
   assign mode_p = press[0];
   assign inc_p  = press[1];
   assign inc_ok = inc_p & ~mode_p & (state != RUN);
   assign hour_ok  = cur_hour[3:0] <= 4'd9 && cur_hour[7:4] <= 4'd9 && cur_hour <= 8'h23;
   assign min_ok   = cur_min[3:0] <= 4'd9 && cur_min[7:4] <= 4'd9 && cur_min <= 8'h59;
   assign hour_inc = load_hour == 8'h23 ? 8'h00 :
                     load_hour[3:0] == 4'd9 ? {load_hour[7:4] + 4'd1, 4'd0} :
                     {load_hour[7:4], load_hour[3:0] + 4'd1};
   assign min_inc  = load_min == 8'h59 ? 8'h00 :
                     load_min[3:0] == 4'd9 ? {load_min[7:4] + 4'd1, 4'd0} :
                     {load_min[7:4], load_min[3:0] + 4'd1};
   always_comb begin
      state_n = state;
      if (mode_p)
         state_n = state == RUN ? SET_H : state == SET_H ? SET_M : RUN;
      hour_n = load_hour;
      min_n  = load_min;
      if (state == RUN && state_n == SET_H) begin
         hour_n = hour_ok ? cur_hour : 8'h00;
         min_n  = min_ok ? cur_min : 8'h00;
      end else if (inc_ok) begin
         hour_n = state == SET_H ? hour_inc : load_hour;
         min_n  = state == SET_M ? min_inc : load_min;
      end
      bcnt_n  = bcnt + BW'(1);
      phase_n = phase;
      // digits restart visible on entry and on every accepted increment
      if (state_n == RUN || state_n != state || inc_ok) begin
         bcnt_n  = '0;
         phase_n = 1'b0;
      end else if (bcnt == BW'(BLINK_MAX)) begin
         bcnt_n  = '0;
         phase_n = ~phase;
      end
      blank_n = state_n == SET_H ? {phase_n, phase_n, 4'b0000} :
                state_n == SET_M ? {2'b00, phase_n, phase_n, 2'b00} : 6'b000000;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= RUN;
         run_en    <= 1'b1;
         load      <= 1'b0;
         load_hour <= 8'h00;
         load_min  <= 8'h00;
         bcnt      <= '0;
         phase     <= 1'b0;
         blank     <= '0;
      end else begin
         state     <= state_n;
         run_en    <= state_n == RUN;
         load      <= state == SET_M && state_n == RUN;
         load_hour <= hour_n;
         load_min  <= min_n;
         bcnt      <= bcnt_n;
         phase     <= phase_n;
         blank     <= blank_n;
      end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of debounce, edit, load, blink and reset behaviour.
module tb_clock_set_ctrl;
   logic clk = 0, reset = 1, btn_mode = 0, btn_inc = 0;
   logic [7:0] cur_hour = 8'h00, cur_min = 8'h00;
   logic run_en, load;
   logic [7:0] load_hour, load_min;
   logic [5:0] blank;
   int n_assert = 0, n_fail = 0, nload;
   clock_set_ctrl #(.DEBOUNCE_MAX(3), .BLINK_MAX(7)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hour(cur_hour), .cur_min(cur_min), .run_en(run_en), .load(load),
      .load_hour(load_hour), .load_min(load_min), .blank(blank));
   always #5 clk = ~clk;
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic m, input logic i);
      btn_mode = m;
      btn_inc  = i;
      cyc(8);
      btn_mode = 0;
      btn_inc  = 0;
      cyc(8);
   endtask
   initial begin
      cyc(3);
      chk("rst_run_en", run_en, 1);
      chk("rst_load", load, 0);
      chk("rst_hour", load_hour, 8'h00);
      chk("rst_min", load_min, 8'h00);
      chk("rst_blank", blank, 0);
      reset = 0;
      cyc(2);
      push(0, 1);
      chk("run_inc_run_en", run_en, 1);
      chk("run_inc_hour", load_hour, 8'h00);
      chk("run_inc_blank", blank, 0);
      cur_hour = 8'h21;
      cur_min  = 8'h45;
      btn_mode = 1;
      cyc(6);
      chk("lat_before", run_en, 1);
      cyc(1);
      chk("lat_run_en", run_en, 0);
      chk("snap_hour", load_hour, 8'h21);
      chk("snap_min", load_min, 8'h45);
      cyc(2);
      btn_mode = 0;
      cyc(8);
      push(0, 1);
      chk("hour22", load_hour, 8'h22);
      push(0, 1);
      chk("hour23", load_hour, 8'h23);
      push(0, 1);
      chk("hour00", load_hour, 8'h00);
      push(1, 0);
      chk("setm_run_en", run_en, 0);
      chk("setm_load", load, 0);
      btn_mode = 1;
      cyc(6);
      chk("load_before", load, 0);
      cyc(1);
      chk("load_pulse", load, 1);
      chk("load_run_en", run_en, 1);
      chk("load_hour", load_hour, 8'h00);
      chk("load_min", load_min, 8'h45);
      cyc(1);
      chk("load_fall", load, 0);
      cyc(6);
      btn_mode = 0;
      cyc(8);
      cur_min = 8'h58;
      push(1, 0);
      chk("snap_min58", load_min, 8'h58);
      chk("snap_hour21", load_hour, 8'h21);
      push(1, 0);
      push(0, 1);
      chk("min59", load_min, 8'h59);
      push(0, 1);
      chk("min00", load_min, 8'h00);
      chk("min_hour_kept", load_hour, 8'h21);
      push(1, 0);
      chk("back_run", run_en, 1);
      cur_hour = 8'h2A;
      push(1, 0);
      chk("sanitize_hour", load_hour, 8'h00);
      chk("sanitize_min_ok", load_min, 8'h58);
      push(1, 0);
      push(1, 0);
      chk("run_again", run_en, 1);
      btn_mode = 1;
      cyc(2);
      btn_mode = 0;
      cyc(10);
      chk("glitch", run_en, 1);
      btn_mode = 1;
      cyc(40);
      chk("held_one", run_en, 0);
      btn_mode = 0;
      cyc(8);
      push(0, 1);
      chk("held_seth_hour", load_hour, 8'h01);
      chk("held_seth_min", load_min, 8'h58);
      push(1, 1);
      chk("simul_hour", load_hour, 8'h01);
      chk("simul_min", load_min, 8'h58);
      chk("simul_run_en", run_en, 0);
      push(0, 1);
      chk("simul_setm", load_min, 8'h59);
      push(1, 0);
      chk("run_before_blink", run_en, 1);
      cur_hour = 8'h12;
      cur_min  = 8'h34;
      btn_mode = 1;
      cyc(7);
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("blink_h%0d", i), blank, (i >= 8 && i < 16) ? 8'h30 : 8'h00);
         cyc(1);
      end
      btn_mode = 0;
      cyc(8);
      btn_inc = 1;
      cyc(7);
      chk("blink_inc_hour", load_hour, 8'h13);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("blink_inc%0d", i), blank, i == 8 ? 8'h30 : 8'h00);
         cyc(1);
      end
      btn_inc = 0;
      cyc(8);
      btn_mode = 1;
      cyc(7);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("blink_m%0d", i), blank, i == 8 ? 8'h0C : 8'h00);
         cyc(1);
      end
      btn_mode = 0;
      cyc(3);
      chk("pre_reset_run_en", run_en, 0);
      reset = 1;
      #1;
      chk("mid_rst_run_en", run_en, 1);
      chk("mid_rst_load", load, 0);
      chk("mid_rst_blank", blank, 0);
      chk("mid_rst_hour", load_hour, 8'h00);
      chk("mid_rst_min", load_min, 8'h00);
      cyc(2);
      reset = 0;
      nload = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (load) nload++;
      end
      chk("no_load_after_rst", 8'(nload), 8'd0);
      chk("run_after_rst", run_en, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
